// File: rtl/FHE_ALU_PKG.sv
// rtl/FHE_ALU_PKG.sv - shared constants and types for the Benes network sequencer
package FHE_ALU_PKG;

    localparam int BENES_LOG_N   = 3;
    localparam int BENES_STAGES  = 2 * BENES_LOG_N - 1;
    localparam int BENES_SW      = (1 << BENES_LOG_N) / 2;
    localparam int BENES_NUM_CFG = 4;
    localparam int BENES_BEAT_W  = 16;

    typedef logic [BENES_SW-1:0]               benes_stage_cfg_t;
    typedef logic [$clog2(BENES_NUM_CFG)-1:0]  benes_slot_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } benes_state_t;

    // Saturating 32-bit increment used by the statistics counters
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/benes_cfg_table.sv
// rtl/benes_cfg_table.sv - slot x stage switch-setting register file, one write port, per-stage read ports
module benes_cfg_table
    import FHE_ALU_PKG::*;
#(
    parameter  int NUM_CFG = BENES_NUM_CFG,
    parameter  int STAGES  = BENES_STAGES,
    parameter  int SW      = BENES_SW,
    localparam int SLOT_W  = $clog2(NUM_CFG),
    localparam int STG_W   = $clog2(STAGES)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_we,
    input  logic [SLOT_W-1:0]        i_wr_slot,
    input  logic [STG_W-1:0]         i_wr_stage,
    input  logic [SW-1:0]            i_wr_bits,
    input  logic [STAGES*SLOT_W-1:0] i_rd_slot,
    output logic [STAGES*SW-1:0]     o_rd_bits
);

    logic [SW-1:0] r_tbl [NUM_CFG][STAGES];

    // Single write port; the whole table returns to all-bar on reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CFG; c++) begin
                for (int s = 0; s < STAGES; s++) begin
                    r_tbl[c][s] <= '0;
                end
            end
        end else if (i_we) begin
            for (int c = 0; c < NUM_CFG; c++) begin
                for (int s = 0; s < STAGES; s++) begin
                    if ((i_wr_slot == SLOT_W'(c)) && (i_wr_stage == STG_W'(s))) begin
                        r_tbl[c][s] <= i_wr_bits;
                    end
                end
            end
        end
    end

    // Each stage reads its own column using the slot that its current beat carries
    for (genvar s = 0; s < STAGES; s++) begin : g_rd
        assign o_rd_bits[s*SW +: SW] = r_tbl[i_rd_slot[s*SLOT_W +: SLOT_W]][s];
    end

endmodule

// File: rtl/benes_switch_sched.sv
// rtl/benes_switch_sched.sv - Benes network configuration sequencer (optional stats: BENES_SCHED_STATS_EN)
module benes_switch_sched
    import FHE_ALU_PKG::*;
#(
    parameter  int LOG_N   = BENES_LOG_N,
    parameter  int NUM_CFG = BENES_NUM_CFG,
    parameter  int BEAT_W  = BENES_BEAT_W,
    localparam int STAGES  = 2 * LOG_N - 1,
    localparam int SW      = (1 << LOG_N) / 2,
    localparam int SLOT_W  = $clog2(NUM_CFG),
    localparam int STG_W   = $clog2(STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [SLOT_W-1:0]     cfg_slot,
    input  logic [STG_W-1:0]      cfg_stage,
    input  logic [SW-1:0]         cfg_bits,
    output logic                  cfg_err,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [SLOT_W-1:0]     req_slot,
    input  logic [BEAT_W-1:0]     req_beats,
    input  logic                  src_valid,
    output logic                  src_ready,
    output logic [STAGES*SW-1:0]  net_sw_set,
    output logic                  net_out_valid,
    output logic                  busy,
    output logic                  done
`ifdef BENES_SCHED_STATS_EN
    ,
    output logic [31:0]           perm_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    benes_state_t        r_state;
    benes_state_t        w_state_nxt;
    logic [SLOT_W-1:0]   r_cur_slot;
    logic [SLOT_W-1:0]   w_cur_slot_nxt;
    logic [BEAT_W-1:0]   r_remain;
    logic [BEAT_W-1:0]   w_remain_nxt;
    logic                r_alive;
    logic                r_zero_done;
    logic                w_zero_done_nxt;
    logic                w_fire;
    logic                w_last;
    logic                w_accept;
    logic                w_busy;
    logic                w_cfg_ok;
    logic                r_cfg_err;
    logic                r_out_valid;

    logic [SLOT_W-1:0]      r_slot_pipe [1:STAGES-1];
    logic [STAGES-1:1]      r_vld_pipe;
    logic [STAGES-1:0]      w_vld;
    logic [STAGES*SLOT_W-1:0] w_rd_slot;
    logic [STAGES*SW-1:0]   w_rd_bits;

    // FSM next state, request/beat handshakes and the done pulse
    always_comb begin
        w_state_nxt     = r_state;
        w_cur_slot_nxt  = r_cur_slot;
        w_remain_nxt    = r_remain;
        w_zero_done_nxt = 1'b0;
        src_ready       = (r_state == ST_RUN);
        w_fire          = src_valid && src_ready;
        w_last          = w_fire && (r_remain == BEAT_W'(1));
        // Ready during the last-beat cycle lets the next permutation start with no bubble
        req_ready       = r_alive && ((r_state == ST_IDLE) || w_last);
        w_accept        = req_valid && req_ready;
        done            = w_last || r_zero_done;

        if (w_fire) begin
            w_remain_nxt = r_remain - BEAT_W'(1);
        end
        if (w_accept) begin
            w_cur_slot_nxt = req_slot;
            w_remain_nxt   = req_beats;
            if (req_beats == '0) begin
                w_zero_done_nxt = 1'b1;
                w_state_nxt     = ST_IDLE;
            end else begin
                w_state_nxt     = ST_RUN;
            end
        end else if (w_last) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // FSM state register and request bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cur_slot  <= '0;
            r_remain    <= '0;
            r_zero_done <= 1'b0;
            r_alive     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cur_slot  <= w_cur_slot_nxt;
            r_remain    <= w_remain_nxt;
            r_zero_done <= w_zero_done_nxt;
            r_alive     <= 1'b1;
        end
    end

    // Slot/valid pipes follow each beat one stage per cycle, bubbles included
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld_pipe  <= '0;
            r_out_valid <= 1'b0;
            for (int s = 1; s < STAGES; s++) begin
                r_slot_pipe[s] <= '0;
            end
        end else begin
            r_vld_pipe[1]  <= w_fire;
            r_slot_pipe[1] <= r_cur_slot;
            for (int s = 2; s < STAGES; s++) begin
                r_vld_pipe[s]  <= r_vld_pipe[s-1];
                r_slot_pipe[s] <= r_slot_pipe[s-1];
            end
            r_out_valid <= r_vld_pipe[STAGES-1];
        end
    end

    assign w_busy   = (r_state == ST_RUN) || (|r_vld_pipe);
    assign w_cfg_ok = cfg_we && !w_busy && (cfg_stage < STG_W'(STAGES));

    // Rejected writes (network busy or stage out of range) flag an error one cycle later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
        end
    end

    assign w_vld = {r_vld_pipe, w_fire};

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_head
            assign w_rd_slot[0 +: SLOT_W] = r_cur_slot;
        end else begin : g_tail
            assign w_rd_slot[s*SLOT_W +: SLOT_W] = r_slot_pipe[s];
        end
        // Empty stages are parked in bar so stray data is never crossed
        assign net_sw_set[s*SW +: SW] = w_vld[s] ? w_rd_bits[s*SW +: SW] : '0;
    end

    benes_cfg_table #(
        .NUM_CFG (NUM_CFG),
        .STAGES  (STAGES),
        .SW      (SW)
    ) u_table (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_we       (w_cfg_ok),
        .i_wr_slot  (cfg_slot),
        .i_wr_stage (cfg_stage),
        .i_wr_bits  (cfg_bits),
        .i_rd_slot  (w_rd_slot),
        .o_rd_bits  (w_rd_bits)
    );

    assign cfg_err       = r_cfg_err;
    assign net_out_valid = r_out_valid;
    assign busy          = w_busy;

`ifdef BENES_SCHED_STATS_EN
    logic [31:0] r_perm_cnt;
    logic [31:0] r_stall_cnt;

    // Saturating counts of accepted requests and upstream stall cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perm_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_perm_cnt <= sat_inc32(r_perm_cnt);
            end
            if ((r_state == ST_RUN) && !src_valid) begin
                r_stall_cnt <= sat_inc32(r_stall_cnt);
            end
        end
    end

    assign perm_cnt  = r_perm_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_benes_switch_sched.sv
// tb/tb_benes_switch_sched.sv - directed self-checking bench for benes_switch_sched
module tb_benes_switch_sched;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [1:0]  cfg_slot;
    logic [2:0]  cfg_stage;
    logic [3:0]  cfg_bits;
    logic        cfg_err;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_slot;
    logic [15:0] req_beats;
    logic        src_valid;
    logic        src_ready;
    logic [19:0] net_sw_set;
    logic        net_out_valid;
    logic        busy;
    logic        done;
`ifdef BENES_SCHED_STATS_EN
    logic [31:0] perm_cnt;
    logic [31:0] stall_cnt;
`endif

    int vecs;
    int errs;

    benes_switch_sched dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .cfg_slot      (cfg_slot),
        .cfg_stage     (cfg_stage),
        .cfg_bits      (cfg_bits),
        .cfg_err       (cfg_err),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_slot      (req_slot),
        .req_beats     (req_beats),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .net_sw_set    (net_sw_set),
        .net_out_valid (net_out_valid),
        .busy          (busy),
        .done          (done)
`ifdef BENES_SCHED_STATS_EN
        ,
        .perm_cnt      (perm_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        vecs++; if (req_ready !== 1'b0) begin errs++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
        vecs++; if (src_ready !== 1'b0) begin errs++; $display("FAIL rst_src_ready got %b exp 0", src_ready); end
        vecs++; if (net_sw_set !== 20'h0) begin errs++; $display("FAIL rst_sw got %h exp 00000", net_sw_set); end
        vecs++; if ({net_out_valid, busy, done, cfg_err} !== 4'b0) begin
            errs++; $display("FAIL rst_flags got %b exp 0000", {net_out_valid, busy, done, cfg_err});
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL rst_release_req_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_cfg_write();
        logic [1:0] sl [15];
        logic [2:0] st [15];
        logic [3:0] bt [15];
        sl = '{1,1,1,1,1, 0,0,0,0,0, 2,2,2,2,2};
        st = '{0,1,2,3,4, 0,1,2,3,4, 0,1,2,3,4};
        bt = '{4'hA,4'h5,4'hF,4'h0,4'h3, 4'hF,4'hF,4'hF,4'hF,4'hF, 4'h0,4'h0,4'h0,4'h0,4'h0};
        for (int i = 0; i < 15; i++) begin
            cfg_we = 1'b1; cfg_slot = sl[i]; cfg_stage = st[i]; cfg_bits = bt[i];
            @(negedge clk);
            cfg_we = 1'b0;
            #1;
            vecs++; if (cfg_err !== 1'b0) begin errs++; $display("FAIL cfg_write_err[%0d] got %b exp 0", i, cfg_err); end
        end
    endtask

    task automatic test_single_perm();
        logic [19:0] esw [9];
        logic        eov [9];
        logic        edn [9];
        logic        eby [9];
        esw = '{20'h0000A, 20'h0005A, 20'h00F5A, 20'h00F50, 20'h30F00, 20'h30000, 20'h30000, 20'h00000, 20'h00000};
        eov = '{0,0,0,0,0,1,1,1,0};
        edn = '{0,0,1,0,0,0,0,0,0};
        eby = '{1,1,1,1,1,1,1,0,0};
        @(negedge clk);
        req_valid = 1'b1; req_slot = 2'd1; req_beats = 16'd3;
        #1;
        vecs++; if (req_ready !== 1'b1 || src_ready !== 1'b0) begin
            errs++; $display("FAIL single_accept got rdy=%b src=%b exp 1 0", req_ready, src_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 9; c++) begin
            src_valid = (c < 4);
            #1;
            vecs++; if (net_sw_set !== esw[c]) begin errs++; $display("FAIL single_sw[%0d] got %h exp %h", c, net_sw_set, esw[c]); end
            vecs++; if (net_out_valid !== eov[c]) begin errs++; $display("FAIL single_ov[%0d] got %b exp %b", c, net_out_valid, eov[c]); end
            vecs++; if (done !== edn[c]) begin errs++; $display("FAIL single_done[%0d] got %b exp %b", c, done, edn[c]); end
            vecs++; if (busy !== eby[c]) begin errs++; $display("FAIL single_busy[%0d] got %b exp %b", c, busy, eby[c]); end
            @(negedge clk);
        end
        src_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [19:0] esw [10];
        logic        eov [10];
        logic        edn [10];
        logic        eby [10];
        logic        esr [10];
        esw = '{20'h0000F, 20'h000FF, 20'h00FF0, 20'h0FF00, 20'hFF000, 20'hF0000, 20'h0, 20'h0, 20'h0, 20'h0};
        eov = '{0,0,0,0,0,1,1,1,1,0};
        edn = '{0,1,0,1,0,0,0,0,0,0};
        eby = '{1,1,1,1,1,1,1,1,0,0};
        esr = '{1,1,1,1,0,0,0,0,0,0};
        req_valid = 1'b1; req_slot = 2'd0; req_beats = 16'd2;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            src_valid = (c < 4);
            req_valid = (c == 1);
            req_slot  = 2'd2;
            req_beats = 16'd2;
            #1;
            if (c == 1) begin
                vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL b2b_req_ready got %b exp 1", req_ready); end
            end
            vecs++; if (net_sw_set !== esw[c]) begin errs++; $display("FAIL b2b_sw[%0d] got %h exp %h", c, net_sw_set, esw[c]); end
            vecs++; if (net_out_valid !== eov[c]) begin errs++; $display("FAIL b2b_ov[%0d] got %b exp %b", c, net_out_valid, eov[c]); end
            vecs++; if (done !== edn[c]) begin errs++; $display("FAIL b2b_done[%0d] got %b exp %b", c, done, edn[c]); end
            vecs++; if (busy !== eby[c]) begin errs++; $display("FAIL b2b_busy[%0d] got %b exp %b", c, busy, eby[c]); end
            vecs++; if (src_ready !== esr[c]) begin errs++; $display("FAIL b2b_src_ready[%0d] got %b exp %b", c, src_ready, esr[c]); end
            @(negedge clk);
        end
        req_valid = 1'b0; src_valid = 1'b0;
    endtask

    task automatic test_stall();
        logic        esv [8];
        logic [19:0] esw [8];
        logic        eov [8];
        logic        edn [8];
        logic        eby [8];
        esv = '{1,0,1,0,0,0,0,0};
        esw = '{20'h0000A, 20'h00050, 20'h00F0A, 20'h00050, 20'h30F00, 20'h00000, 20'h30000, 20'h00000};
        eov = '{0,0,0,0,0,1,0,1};
        edn = '{0,0,1,0,0,0,0,0};
        eby = '{1,1,1,1,1,1,1,0};
        req_valid = 1'b1; req_slot = 2'd1; req_beats = 16'd2;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            src_valid = esv[c];
            #1;
            vecs++; if (net_sw_set !== esw[c]) begin errs++; $display("FAIL stall_sw[%0d] got %h exp %h", c, net_sw_set, esw[c]); end
            vecs++; if (net_out_valid !== eov[c]) begin errs++; $display("FAIL stall_ov[%0d] got %b exp %b", c, net_out_valid, eov[c]); end
            vecs++; if (done !== edn[c]) begin errs++; $display("FAIL stall_done[%0d] got %b exp %b", c, done, edn[c]); end
            vecs++; if (busy !== eby[c]) begin errs++; $display("FAIL stall_busy[%0d] got %b exp %b", c, busy, eby[c]); end
            @(negedge clk);
        end
        src_valid = 1'b0;
    endtask

    task automatic test_cfg_err();
        cfg_we = 1'b1; cfg_slot = 2'd1; cfg_stage = 3'd6; cfg_bits = 4'hC;
        @(negedge clk);
        cfg_we = 1'b0;
        #1;
        vecs++; if (cfg_err !== 1'b1) begin errs++; $display("FAIL err_range got %b exp 1", cfg_err); end
        @(negedge clk); #1;
        vecs++; if (cfg_err !== 1'b0) begin errs++; $display("FAIL err_range_clear got %b exp 0", cfg_err); end
        req_valid = 1'b1; req_slot = 2'd1; req_beats = 16'd1;
        @(negedge clk);
        req_valid = 1'b0; src_valid = 1'b1;
        cfg_we = 1'b1; cfg_slot = 2'd1; cfg_stage = 3'd0; cfg_bits = 4'h7;
        #1;
        vecs++; if (busy !== 1'b1 || done !== 1'b1) begin errs++; $display("FAIL err_busy_state got busy=%b done=%b exp 1 1", busy, done); end
        vecs++; if (net_sw_set !== 20'h0000A) begin errs++; $display("FAIL err_busy_sw0 got %h exp 0000A", net_sw_set); end
        @(negedge clk);
        src_valid = 1'b0; cfg_we = 1'b0;
        #1;
        vecs++; if (cfg_err !== 1'b1) begin errs++; $display("FAIL err_busy got %b exp 1", cfg_err); end
        vecs++; if (net_sw_set !== 20'h00050) begin errs++; $display("FAIL err_busy_sw1 got %h exp 00050", net_sw_set); end
        repeat (4) @(negedge clk);
        #1;
        vecs++; if (busy !== 1'b0 || cfg_err !== 1'b0) begin errs++; $display("FAIL err_drain got busy=%b err=%b exp 0 0", busy, cfg_err); end
        req_valid = 1'b1; req_slot = 2'd1; req_beats = 16'd1;
        @(negedge clk);
        req_valid = 1'b0; src_valid = 1'b1;
        #1;
        vecs++; if (net_sw_set !== 20'h0000A) begin errs++; $display("FAIL err_table_kept got %h exp 0000A", net_sw_set); end
        @(negedge clk);
        src_valid = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_zero_beats();
        req_valid = 1'b1; req_slot = 2'd1; req_beats = 16'd0;
        #1;
        vecs++; if (req_ready !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL zero_accept got rdy=%b done=%b exp 1 0", req_ready, done); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        vecs++; if (done !== 1'b1) begin errs++; $display("FAIL zero_done got %b exp 1", done); end
        vecs++; if (src_ready !== 1'b0 || req_ready !== 1'b1) begin errs++; $display("FAIL zero_ready got src=%b req=%b exp 0 1", src_ready, req_ready); end
        @(negedge clk); #1;
        vecs++; if (done !== 1'b0 || src_ready !== 1'b0) begin errs++; $display("FAIL zero_after got done=%b src=%b exp 0 0", done, src_ready); end
    endtask

    task automatic test_reset_mid_run();
        req_valid = 1'b1; req_slot = 2'd1; req_beats = 16'd3;
        @(negedge clk);
        req_valid = 1'b0; src_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; src_valid = 1'b0;
        #1;
        vecs++; if ({req_ready, src_ready, busy, done, net_out_valid, cfg_err} !== 6'b0) begin
            errs++; $display("FAIL midrst_flags got %b exp 000000", {req_ready, src_ready, busy, done, net_out_valid, cfg_err});
        end
        vecs++; if (net_sw_set !== 20'h0) begin errs++; $display("FAIL midrst_sw got %h exp 00000", net_sw_set); end
        @(negedge clk); #1;
        vecs++; if (req_ready !== 1'b1) begin errs++; $display("FAIL midrst_req_ready got %b exp 1", req_ready); end
        for (int c = 0; c < 7; c++) begin
            vecs++; if ({net_out_valid, done, busy} !== 3'b0) begin
                errs++; $display("FAIL midrst_quiet[%0d] got %b exp 000", c, {net_out_valid, done, busy});
            end
            @(negedge clk); #1;
        end
        req_valid = 1'b1; req_slot = 2'd1; req_beats = 16'd1;
        @(negedge clk);
        req_valid = 1'b0; src_valid = 1'b1;
        #1;
        vecs++; if (src_ready !== 1'b1 || done !== 1'b1) begin errs++; $display("FAIL midrst_refire got src=%b done=%b exp 1 1", src_ready, done); end
        vecs++; if (net_sw_set !== 20'h0) begin errs++; $display("FAIL midrst_table_bar got %h exp 00000", net_sw_set); end
        @(negedge clk);
        src_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        vecs++; if (net_out_valid !== 1'b1) begin errs++; $display("FAIL midrst_out_valid got %b exp 1", net_out_valid); end
        @(negedge clk);
    endtask

    initial begin
        vecs = 0; errs = 0;
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_slot = '0; cfg_stage = '0; cfg_bits = '0;
        req_valid = 1'b0; req_slot = '0; req_beats = '0;
        src_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        test_reset();
        test_cfg_write();
        test_single_perm();
        test_back_to_back();
        test_stall();
        test_cfg_err();
        test_zero_beats();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
